// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the main-memory access controller and its arbiter.
package mem_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_READ_LATENCY = 1;
  localparam int LAT_CNT_WIDTH    = 4;

  localparam logic CH_FETCH = 1'b0;
  localparam logic CH_DATA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } state_e;

  function automatic logic other_channel(input logic ch);
    return (ch == CH_DATA) ? CH_FETCH : CH_DATA;
  endfunction

endpackage

// File: rtl/mem_access_controller_rr_arbiter2.sv
// Two-request round-robin arbiter; the channel not granted last wins a tie.
module rr_arbiter2
  import mem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic req_fetch_i,
  input  logic req_data_i,
  input  logic accept_i,
  output logic gnt_fetch_o,
  output logic gnt_data_o,
  output logic gnt_id_o
);

  logic last_grant_q;
  logic last_grant_d;
  logic tie_winner;

  assign tie_winner = other_channel(last_grant_q);

  always_comb begin
    gnt_fetch_o = 1'b0;
    gnt_data_o  = 1'b0;
    if (enable_i) begin
      if (req_fetch_i && req_data_i) begin
        gnt_fetch_o = (tie_winner == CH_FETCH);
        gnt_data_o  = (tie_winner == CH_DATA);
      end else begin
        gnt_fetch_o = req_fetch_i;
        gnt_data_o  = req_data_i;
      end
    end
  end

  assign gnt_id_o     = gnt_data_o ? CH_DATA : CH_FETCH;
  assign last_grant_d = accept_i ? gnt_id_o : last_grant_q;

  // Reset leaves DATA as last winner so a tie straight out of reset goes to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= CH_DATA;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_access_controller.sv
// Arbitrates instruction-fetch and load/store requests onto one single-port
// synchronous main memory with byte-enabled writes and a configurable read latency.
module mem_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req_valid,
  output logic                    if_req_ready,
  input  logic [ADDR_WIDTH-1:0]   if_req_addr,
  output logic                    if_rsp_valid,
  output logic [DATA_WIDTH-1:0]   if_rsp_data,
  input  logic                    d_req_valid,
  output logic                    d_req_ready,
  input  logic                    d_req_we,
  input  logic [ADDR_WIDTH-1:0]   d_req_addr,
  input  logic [DATA_WIDTH-1:0]   d_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_req_be,
  output logic                    d_rsp_valid,
  output logic [DATA_WIDTH-1:0]   d_rsp_data,
  output logic [ADDR_WIDTH-1:0]   mem_read_address,
  output logic [ADDR_WIDTH-1:0]   mem_write_address,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic                    mem_write_enable,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  input  logic [DATA_WIDTH-1:0]   mem_read_data,
  output logic                    busy
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [LAT_CNT_WIDTH-1:0] LAT_LAST = LAT_CNT_WIDTH'(READ_LATENCY);

  state_e                   state_q, state_d;
  logic                     ch_q, ch_d;
  logic [LAT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]    mem_read_address_q, mem_read_address_d;
  logic [ADDR_WIDTH-1:0]    mem_write_address_q, mem_write_address_d;
  logic [DATA_WIDTH-1:0]    mem_write_data_q, mem_write_data_d;
  logic                     mem_write_enable_q, mem_write_enable_d;
  logic [BE_WIDTH-1:0]      mem_byte_enable_q, mem_byte_enable_d;
  logic                     if_rsp_valid_q, if_rsp_valid_d;
  logic [DATA_WIDTH-1:0]    if_rsp_data_q, if_rsp_data_d;
  logic                     d_rsp_valid_q, d_rsp_valid_d;
  logic [DATA_WIDTH-1:0]    d_rsp_data_q, d_rsp_data_d;

  logic arb_enable;
  logic gnt_fetch;
  logic gnt_data;
  logic gnt_id;
  logic accept;

  // Requests are only considered while idle and out of reset, so ready never leaks.
  assign arb_enable = (state_q == IDLE) && rst_n;
  assign accept     = (if_req_valid && gnt_fetch) || (d_req_valid && gnt_data);

  rr_arbiter2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (arb_enable),
    .req_fetch_i (if_req_valid),
    .req_data_i  (d_req_valid),
    .accept_i    (accept),
    .gnt_fetch_o (gnt_fetch),
    .gnt_data_o  (gnt_data),
    .gnt_id_o    (gnt_id)
  );

  assign if_req_ready = gnt_fetch;
  assign d_req_ready  = gnt_data;

  always_comb begin
    state_d             = state_q;
    ch_d                = ch_q;
    cnt_d               = cnt_q;
    mem_read_address_d  = mem_read_address_q;
    mem_write_address_d = mem_write_address_q;
    mem_write_data_d    = mem_write_data_q;
    mem_write_enable_d  = 1'b0;
    mem_byte_enable_d   = '0;
    if_rsp_valid_d      = 1'b0;
    if_rsp_data_d       = if_rsp_data_q;
    d_rsp_valid_d       = 1'b0;
    d_rsp_data_d        = d_rsp_data_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ch_d = gnt_id;
          // A store is issued and acknowledged in the same following cycle.
          if ((gnt_id == CH_DATA) && d_req_we) begin
            state_d             = WRITE;
            mem_write_address_d = d_req_addr;
            mem_write_data_d    = d_req_wdata;
            mem_byte_enable_d   = d_req_be;
            mem_write_enable_d  = 1'b1;
            d_rsp_valid_d       = 1'b1;
            d_rsp_data_d        = '0;
          end else begin
            state_d            = READ;
            cnt_d              = '0;
            mem_read_address_d = (gnt_id == CH_DATA) ? d_req_addr : if_req_addr;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      READ: begin
        if (cnt_q == LAT_LAST) begin
          state_d = RESP;
          if (ch_q == CH_DATA) begin
            d_rsp_data_d  = mem_read_data;
            d_rsp_valid_d = 1'b1;
          end else begin
            if_rsp_data_d  = mem_read_data;
            if_rsp_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      ch_q                <= CH_DATA;
      cnt_q               <= '0;
      mem_read_address_q  <= '0;
      mem_write_address_q <= '0;
      mem_write_data_q    <= '0;
      mem_write_enable_q  <= 1'b0;
      mem_byte_enable_q   <= '0;
      if_rsp_valid_q      <= 1'b0;
      if_rsp_data_q       <= '0;
      d_rsp_valid_q       <= 1'b0;
      d_rsp_data_q        <= '0;
    end else begin
      state_q             <= state_d;
      ch_q                <= ch_d;
      cnt_q               <= cnt_d;
      mem_read_address_q  <= mem_read_address_d;
      mem_write_address_q <= mem_write_address_d;
      mem_write_data_q    <= mem_write_data_d;
      mem_write_enable_q  <= mem_write_enable_d;
      mem_byte_enable_q   <= mem_byte_enable_d;
      if_rsp_valid_q      <= if_rsp_valid_d;
      if_rsp_data_q       <= if_rsp_data_d;
      d_rsp_valid_q       <= d_rsp_valid_d;
      d_rsp_data_q        <= d_rsp_data_d;
    end
  end

  assign mem_read_address  = mem_read_address_q;
  assign mem_write_address = mem_write_address_q;
  assign mem_write_data    = mem_write_data_q;
  assign mem_write_enable  = mem_write_enable_q;
  assign mem_byte_enable   = mem_byte_enable_q;
  assign if_rsp_valid      = if_rsp_valid_q;
  assign if_rsp_data       = if_rsp_data_q;
  assign d_rsp_valid       = d_rsp_valid_q;
  assign d_rsp_data        = d_rsp_data_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: three builds (read latency 0, 1, 3), each with
// its own latency-accurate memory, directed scenarios then random traffic.
module tb_mem_access_controller;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rstN = 1'b1;
  always #5 clk = ~clk;

  logic          ifValid [NI];
  logic          ifReady [NI];
  logic [AW-1:0] ifAddr [NI];
  logic          ifRspValid [NI];
  logic [DW-1:0] ifRspData [NI];
  logic          dValid [NI];
  logic          dReady [NI];
  logic          dWe [NI];
  logic [AW-1:0] dAddr [NI];
  logic [DW-1:0] dWdata [NI];
  logic [BW-1:0] dBe [NI];
  logic          dRspValid [NI];
  logic [DW-1:0] dRspData [NI];
  logic [AW-1:0] memRaddr [NI];
  logic [AW-1:0] memWaddr [NI];
  logic [DW-1:0] memWdata [NI];
  logic          memWe [NI];
  logic [BW-1:0] memBe [NI];
  logic          busy [NI];
  logic          preWe [NI];
  logic [AW-1:0] preAddr [NI];
  logic [DW-1:0] preData [NI];

  int total = 0;
  int bad = 0;
  bit monOn = 1'b0;
  int lastGrant [NI];
  logic [DW-1:0] refMem [NI][8];

  // Instance 0 uses latency 0, instance 1 latency 1, instance 2 latency 3.
  for (genvar g = 0; g < NI; g++) begin : gInst
    localparam int RL = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic [DW-1:0] memArr [256];
    logic [DW-1:0] pipe [16];
    logic [DW-1:0] rdata;

    mem_access_controller #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .READ_LATENCY (RL)
    ) dut (
      .clk               (clk),
      .rst_n             (rstN),
      .if_req_valid      (ifValid[g]),
      .if_req_ready      (ifReady[g]),
      .if_req_addr       (ifAddr[g]),
      .if_rsp_valid      (ifRspValid[g]),
      .if_rsp_data       (ifRspData[g]),
      .d_req_valid       (dValid[g]),
      .d_req_ready       (dReady[g]),
      .d_req_we          (dWe[g]),
      .d_req_addr        (dAddr[g]),
      .d_req_wdata       (dWdata[g]),
      .d_req_be          (dBe[g]),
      .d_rsp_valid       (dRspValid[g]),
      .d_rsp_data        (dRspData[g]),
      .mem_read_address  (memRaddr[g]),
      .mem_write_address (memWaddr[g]),
      .mem_write_data    (memWdata[g]),
      .mem_write_enable  (memWe[g]),
      .mem_byte_enable   (memBe[g]),
      .mem_read_data     (rdata),
      .busy              (busy[g])
    );

    always_ff @(posedge clk) begin
      if (preWe[g]) begin
        memArr[preAddr[g][9:2]] <= preData[g];
      end else if (memWe[g]) begin
        for (int b = 0; b < BW; b++) begin
          if (memBe[g][b]) memArr[memWaddr[g][9:2]][8*b +: 8] <= memWdata[g][8*b +: 8];
        end
      end
      pipe[0] <= memArr[memRaddr[g][9:2]];
      for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
    end

    if (RL == 0) begin : gComb
      assign rdata = memArr[memRaddr[g][9:2]];
    end else begin : gPipe
      assign rdata = pipe[RL-1];
    end
  end

  function automatic int rlOf(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] oldW, input logic [DW-1:0] newW,
                                               input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = oldW;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = newW[8*b +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int d, input logic fv, input logic [AW-1:0] fa, input logic dv,
                               input logic we, input logic [AW-1:0] da, input logic [DW-1:0] wd,
                               input logic [BW-1:0] be);
    ifValid[d] = fv;
    ifAddr[d]  = fa;
    dValid[d]  = dv;
    dWe[d]     = we;
    dAddr[d]   = da;
    dWdata[d]  = wd;
    dBe[d]     = be;
  endtask

  task automatic preload(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    preWe[d]   = 1'b1;
    preAddr[d] = a;
    preData[d] = v;
    @(negedge clk);
    preWe[d] = 1'b0;
  endtask

  // One random round: fetch, data or both requesters, served in model grant order.
  task automatic randomRound(input int d);
    int pick, fIdx, dIdx, lat, w;
    logic wantF, wantD, we, gnt;
    logic [AW-1:0] fa, da;
    logic [DW-1:0] wd, expData;
    logic [BW-1:0] be;
    pick  = $urandom_range(0, 3);
    wantF = (pick != 1);
    wantD = (pick != 0);
    fIdx  = $urandom_range(0, 7);
    dIdx  = $urandom_range(0, 7);
    fa    = 32'h400 + 32'(fIdx * 4);
    da    = 32'h400 + 32'(dIdx * 4);
    we    = 1'($urandom_range(0, 1));
    wd    = $urandom;
    be    = 4'($urandom_range(0, 15));
    @(negedge clk);
    applyStimulus(d, wantF, fa, wantD, we, da, wd, be);
    while (wantF || wantD) begin
      #1;
      if (wantF && wantD) gnt = (lastGrant[d] == 1) ? 1'b0 : 1'b1;
      else gnt = wantD;
      checkOutput("rrGrant", {ifReady[d], dReady[d]}, gnt ? 2'b01 : 2'b10);
      lastGrant[d] = gnt ? 1 : 0;
      if (!gnt) begin
        expData = refMem[d][fIdx];
        lat     = rlOf(d) + 2;
      end else if (we) begin
        expData = '0;
        lat     = 1;
      end else begin
        expData = refMem[d][dIdx];
        lat     = rlOf(d) + 2;
      end
      @(negedge clk);
      if (!gnt) begin
        wantF      = 1'b0;
        ifValid[d] = 1'b0;
      end else begin
        wantD     = 1'b0;
        dValid[d] = 1'b0;
      end
      w = 1;
      while (!(gnt ? dRspValid[d] : ifRspValid[d]) && w < 40) begin
        @(negedge clk);
        w++;
      end
      checkOutput("rspLatency", 64'(w), 64'(lat));
      checkOutput("rspData", gnt ? dRspData[d] : ifRspData[d], expData);
      if (gnt && we) refMem[d][dIdx] = mergeBytes(refMem[d][dIdx], wd, be);
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      for (int d = 0; d < NI; d++) checkOutput("dualRsp", 64'(ifRspValid[d] & dRspValid[d]), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w;
    bit seen;
    for (int d = 0; d < NI; d++) begin
      applyStimulus(d, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
      preWe[d]     = 1'b0;
      preAddr[d]   = '0;
      preData[d]   = '0;
      lastGrant[d] = 1;
    end
    #2 rstN = 1'b0;

    // Reset state, with a fetch already waiting to prove ready stays low.
    @(negedge clk);
    ifValid[1] = 1'b1;
    #1;
    checkOutput("rstReady", ifReady[1], 1'b0);
    checkOutput("rstBusy", busy[1], 1'b0);
    checkOutput("rstWe", memWe[1], 1'b0);
    checkOutput("rstBe", memBe[1], 4'b0);
    checkOutput("rstRaddr", memRaddr[1], 32'h0);
    checkOutput("rstWaddr", memWaddr[1], 32'h0);
    checkOutput("rstWdata", memWdata[1], 32'h0);
    checkOutput("rstIfRsp", ifRspValid[1], 1'b0);
    checkOutput("rstDRsp", dRspValid[1], 1'b0);
    checkOutput("rstDRspData", dRspData[1], 32'h0);
    ifValid[1] = 1'b0;
    @(negedge clk);
    rstN  = 1'b1;
    monOn = 1'b1;

    preload(1, 32'h100, 32'hDEADBEEF);
    preload(0, 32'h8, 32'hA5A5A5A5);
    preload(2, 32'h40, 32'h11223344);

    $display("[TB] fetch with latency 1");
    @(negedge clk);
    applyStimulus(1, 1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0);
    #1;
    checkOutput("fetchReady", ifReady[1], 1'b1);
    checkOutput("fetchDReadyLow", dReady[1], 1'b0);
    @(negedge clk);
    ifValid[1] = 1'b0;
    checkOutput("fetchRaddrC1", memRaddr[1], 32'h100);
    checkOutput("fetchBusy", busy[1], 1'b1);
    checkOutput("fetchRspC1", ifRspValid[1], 1'b0);
    @(negedge clk);
    checkOutput("fetchRaddrC2", memRaddr[1], 32'h100);
    checkOutput("fetchRspC2", ifRspValid[1], 1'b0);
    @(negedge clk);
    checkOutput("fetchRspValid", ifRspValid[1], 1'b1);
    checkOutput("fetchRspData", ifRspData[1], 32'hDEADBEEF);
    checkOutput("fetchNoDRsp", dRspValid[1], 1'b0);
    @(negedge clk);
    checkOutput("fetchRspPulse", ifRspValid[1], 1'b0);
    checkOutput("fetchDataHold", ifRspData[1], 32'hDEADBEEF);
    checkOutput("fetchIdle", busy[1], 1'b0);

    $display("[TB] partial-byte store");
    applyStimulus(1, 1'b0, '0, 1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011);
    #1;
    checkOutput("storeReady", dReady[1], 1'b1);
    @(negedge clk);
    dValid[1] = 1'b0;
    checkOutput("storeWe", memWe[1], 1'b1);
    checkOutput("storeBe", memBe[1], 4'b0011);
    checkOutput("storeWaddr", memWaddr[1], 32'h200);
    checkOutput("storeWdata", memWdata[1], 32'h12345678);
    checkOutput("storeAck", dRspValid[1], 1'b1);
    checkOutput("storeAckData", dRspData[1], 32'h0);
    @(negedge clk);
    checkOutput("storeWeLow", memWe[1], 1'b0);
    checkOutput("storeBeLow", memBe[1], 4'b0);
    checkOutput("storeAckPulse", dRspValid[1], 1'b0);
    checkOutput("storeWaddrHold", memWaddr[1], 32'h200);

    $display("[TB] back-to-back store then load");
    applyStimulus(1, 1'b0, '0, 1'b1, 1'b1, 32'h300, 32'hCAFEF00D, 4'b1111);
    #1;
    checkOutput("b2bStoreReady", dReady[1], 1'b1);
    @(negedge clk);
    applyStimulus(1, 1'b0, '0, 1'b1, 1'b0, 32'h300, '0, '0);
    #1;
    checkOutput("b2bReadyInWrite", dReady[1], 1'b0);
    @(negedge clk);
    #1;
    checkOutput("b2bLoadReady", dReady[1], 1'b1);
    @(negedge clk);
    dValid[1] = 1'b0;
    checkOutput("b2bRspC1", dRspValid[1], 1'b0);
    @(negedge clk);
    checkOutput("b2bRspC2", dRspValid[1], 1'b0);
    @(negedge clk);
    checkOutput("b2bRspValid", dRspValid[1], 1'b1);
    checkOutput("b2bRspData", dRspData[1], 32'hCAFEF00D);

    $display("[TB] load with latency 0");
    @(negedge clk);
    applyStimulus(0, 1'b0, '0, 1'b1, 1'b0, 32'h8, '0, '0);
    #1;
    checkOutput("rl0Ready", dReady[0], 1'b1);
    @(negedge clk);
    dValid[0] = 1'b0;
    checkOutput("rl0Raddr", memRaddr[0], 32'h8);
    checkOutput("rl0RspC1", dRspValid[0], 1'b0);
    @(negedge clk);
    checkOutput("rl0RspValid", dRspValid[0], 1'b1);
    checkOutput("rl0RspData", dRspData[0], 32'hA5A5A5A5);

    $display("[TB] contention from reset");
    @(negedge clk);
    rstN = 1'b0;
    applyStimulus(1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h104, '0, '0);
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = 0;
      #1;
      while (!(ifReady[1] || dReady[1]) && w < 20) begin
        @(negedge clk);
        #1;
        w++;
      end
      checkOutput("contGrant", {ifReady[1], dReady[1]}, (i % 2 == 0) ? 2'b10 : 2'b01);
      @(negedge clk);
    end
    applyStimulus(1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    repeat (6) @(negedge clk);
    checkOutput("contIdle", busy[1], 1'b0);

    $display("[TB] reset during a latency-3 read");
    applyStimulus(2, 1'b1, 32'h40, 1'b0, 1'b0, '0, '0, '0);
    #1;
    checkOutput("abortReady", ifReady[2], 1'b1);
    @(negedge clk);
    checkOutput("abortBusy", busy[2], 1'b1);
    checkOutput("abortRaddr", memRaddr[2], 32'h40);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("abortRstBusy", busy[2], 1'b0);
    checkOutput("abortRstRaddr", memRaddr[2], 32'h0);
    checkOutput("abortRstReady", ifReady[2], 1'b0);
    checkOutput("abortRstRsp", ifRspValid[2], 1'b0);
    @(negedge clk);
    ifValid[2] = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifRspValid[2] || dRspValid[2]) seen = 1'b1;
    end
    checkOutput("abortNoRsp", seen, 1'b0);
    checkOutput("abortIdle", busy[2], 1'b0);

    $display("[TB] random traffic");
    for (int d = 0; d < NI; d++) begin
      lastGrant[d] = 1;
      for (int i = 0; i < 8; i++) begin
        refMem[d][i] = $urandom;
        preload(d, 32'h400 + 32'(i * 4), refMem[d][i]);
      end
      for (int r = 0; r < 40; r++) randomRound(d);
    end

    monOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Parametrised successor to the single-cycle main-memory mux.
- Arbitrates between the instruction-fetch channel and the data (load/store) channel for one single-port synchronous main memory.
- Uses valid/ready request handshakes, a configurable read latency, byte-enabled writes and registered memory-side outputs.
- Sits between the CPU core (fetch unit, load/store unit) and the main memory model.

Parameters:
- ADDR_WIDTH, 32, width of all addresses.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- READ_LATENCY, 1, cycles from stable mem_read_address to valid mem_read_data; range 0..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted when valid && ready.
- if_req_addr  in  ADDR_WIDTH  fetch address (PC).
- if_rsp_valid  out  1  one-cycle pulse; if_rsp_data valid.
- if_rsp_data  out  DATA_WIDTH  fetched word.
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data request accepted when valid && ready.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_addr  in  ADDR_WIDTH  load/store address.
- d_req_wdata  in  DATA_WIDTH  store data.
- d_req_be  in  DATA_WIDTH/8  store byte enables.
- d_rsp_valid  out  1  one-cycle pulse; load data valid or store acknowledged.
- d_rsp_data  out  DATA_WIDTH  load data; 0 for store ack.
- mem_read_address  out  ADDR_WIDTH  to memory.
- mem_write_address  out  ADDR_WIDTH  to memory.
- mem_write_data  out  DATA_WIDTH  to memory.
- mem_write_enable  out  1  to memory.
- mem_byte_enable  out  DATA_WIDTH/8  to memory.
- mem_read_data  in  DATA_WIDTH  from memory.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, last_grant = DATA, latency counter 0.
  - Reset mid-operation aborts the in-flight access; no response is ever issued for it.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - At most one of if_req_ready/d_req_ready is high, combinationally, for the granted channel only.
  - Only one requester valid: that requester is granted.
  - Both valid: round-robin; grant the channel not equal to last_grant.
  - On accept: latch channel id, addr, wdata, be, and we; update last_grant.
  - Next state: WRITE if data store, otherwise READ.
- WRITE (1 cycle):
  - mem_write_address/mem_write_data/mem_byte_enable come from registers; mem_write_enable = 1.
  - d_rsp_valid = 1 with d_rsp_data = 0 in the same cycle; next state IDLE.
  - be = 0 is still issued with enable = 1 (memory no-op) and acked normally.
- READ:
  - mem_read_address = latched address, held stable; counter increments each cycle.
  - When counter == READ_LATENCY, capture mem_read_data into the response register and go to RESP.
  - READ_LATENCY = 0 captures in the first READ cycle.
- RESP (1 cycle):
  - Pulse rsp_valid on the owning channel with the captured data; next state IDLE.
- Latency:
  - Store: accept to ack = 1 cycle.
  - Load/fetch: accept to rsp_valid = READ_LATENCY + 2 cycles.
  - Minimum accept-to-accept spacing is 2 cycles for a store and READ_LATENCY + 3 for a read.
- Outputs outside active states:
  - mem_write_enable = 0 and mem_byte_enable = 0.
  - mem_read_address and mem_write_address hold their last driven value (registered, no latch).
- rsp_valid never asserts on both channels in the same cycle; rsp_data holds its value between pulses.
- Requests are not cancellable: once accepted, the access completes unless reset.
- Requester inputs are ignored outside IDLE; ready stays low.

Decomposition:
- Shared package mem_ctrl_pkg:
  - state enum (IDLE/WRITE/READ/RESP).
  - channel id constants CH_FETCH = 0, CH_DATA = 1.
  - default width constants.
- Sub-module rr_arbiter2: two-request round-robin grant with a last_grant register; reused for future extra channels.

Test Plan:
- Reset: rst_n low mid-READ (addr 0x40, READ_LATENCY = 3) → all outputs 0 immediately; no rsp_valid after release; busy = 0.
- Fetch only: if_req addr 0x100, memory returns 0xDEADBEEF, READ_LATENCY = 1 → if_rsp_valid high exactly 3 cycles after accept with data 0xDEADBEEF; mem_read_address = 0x100 for 2 cycles.
- Store: d_req we = 1, addr 0x200, wdata 0x12345678, be = 4'b0011 → next cycle mem_write_enable = 1, mem_byte_enable = 0011, d_rsp_valid = 1, d_rsp_data = 0.
- Contention: both valid every cycle from reset → grants alternate DATA-excluded-first (FETCH, DATA, FETCH, DATA); no channel granted twice consecutively.
- READ_LATENCY = 0 build: data load at 0x8 with memory returning 0xA5A5A5A5 → d_rsp_valid 2 cycles after accept with correct data.
- Back-to-back: store then immediate load to the same address 0x300 → load returns the stored value; second accept occurs exactly 2 cycles after the first.
